issue_scoreboard: RTL and testbench

- Sits between instr_decode and the execute stage. Holds one decoded instruction in an issue register.
- Stalls decode on register hazards (RAW/WAW via a busy bitmap), on the in-flight limit, and on a second load/store while one is outstanding.
- Releases busy registers on in-order retirement. Single memory port, so at most one load/store may be outstanding.

---
 rtl/issue_scoreboard.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// -----------------------------------------------------------------------------
// issue_scoreboard
//
// Purpose:
//   Sits between instruction decode and the execute stage. It holds one decoded
//   instruction in an issue register and stalls decode when issuing would be
//   unsafe:
//     - RAW/WAW hazards against a bitmap of pending destination registers,
//     - the issued-but-unretired instruction count reaching MAX_INFLIGHT,
//     - a second load/store while one already owns the single memory port.
//   Busy registers are released as instructions retire in order.
//
// Optional feature (macro WB_BYPASS_EN):
//   Defined   - hazard and in-flight checks look through the retirement
//               happening in the same cycle, so a consumer can be accepted in
//               the cycle its producer retires.
//   Undefined - checks use registered state only. After each retirement there
//               is one extra cycle of stall.
//
// Parameters:
//   MAX_INFLIGHT  maximum issued-but-unretired instructions (1..7)
//   CNT_W         width of the in-flight counter (must hold MAX_INFLIGHT)
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   dec_valid / dec_ready      decode handshake
//   dec_op, dec_rs1/2/rd(_v),  decoded instruction fields
//   dec_imm(_v), dec_ls
//   iss_valid / iss_ready      execute handshake
//   iss_op, iss_rs1/2/rd,      registered instruction presented to execute
//   iss_rd_v, iss_imm(_v),
//   iss_ls
//   ret_valid, ret_rd_v,       in-order retirement of one instruction
//   ret_rd
//   ls_done                    memory port finished the outstanding load/store
//   busy_map                   pending-destination bitmap (bit 0 always 0)
//   inflight                   issued-but-unretired count, including the issue
//                              register
//   stall_raw, stall_ls        combinational stall reasons for the presented
//                              instruction
// -----------------------------------------------------------------------------
module issue_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,

  // Decode side
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [5:0]       dec_op,
  input  logic             dec_rs1_v,
  input  logic             dec_rs2_v,
  input  logic             dec_rd_v,
  input  logic             dec_imm_v,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic [31:0]      dec_imm,
  input  logic             dec_ls,

  // Execute side
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [5:0]       iss_op,
  output logic [4:0]       iss_rs1,
  output logic [4:0]       iss_rs2,
  output logic [4:0]       iss_rd,
  output logic             iss_rd_v,
  output logic             iss_imm_v,
  output logic             iss_ls,
  output logic [31:0]      iss_imm,

  // Retirement and memory port
  input  logic             ret_valid,
  input  logic             ret_rd_v,
  input  logic [4:0]       ret_rd,
  input  logic             ls_done,

  // Status
  output logic [31:0]      busy_map,
  output logic [CNT_W-1:0] inflight,
  output logic             stall_raw,
  output logic             stall_ls
);

  // ---------------------------------------------------------------------------
  // Load/store port state
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    LS_IDLE   = 2'd0,  // memory port free
    LS_QUEUED = 2'd1,  // load/store accepted, still in the issue register
    LS_WAIT   = 2'd2   // load/store handed to execute, waiting for ls_done
  } ls_state_e;

  ls_state_e        ls_state_q, ls_state_d;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  logic             iss_valid_q, iss_valid_d;
  logic [5:0]       iss_op_q;
  logic [4:0]       iss_rs1_q;
  logic [4:0]       iss_rs2_q;
  logic [4:0]       iss_rd_q;
  logic             iss_rd_v_q;
  logic             iss_imm_v_q;
  logic             iss_ls_q;
  logic [31:0]      iss_imm_q;

  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;

  // ---------------------------------------------------------------------------
  // Handshake and hazard terms
  // ---------------------------------------------------------------------------
  logic             accept;     // decode transfer this cycle
  logic             iss_fire;   // execute transfer this cycle
  logic             ret_eff;    // retirement that actually decrements inflight
  logic             ret_clr;    // retirement that clears a busy bit
  logic             raw;
  logic             waw;
  logic             full;
  logic [31:0]      busy_view;  // busy bitmap as seen by the hazard checks
  logic [CNT_W-1:0] inflight_view;

  // A retirement at inflight==0 is spurious; ignoring it prevents underflow.
  assign ret_eff = ret_valid && (inflight_q != '0);
  assign ret_clr = ret_valid && ret_rd_v && (ret_rd != 5'd0);

`ifdef WB_BYPASS_EN
  // Look through the retirement happening this cycle so a dependent
  // instruction does not pay an extra stall cycle.
  logic [31:0] retire_mask;

  always_comb begin
    retire_mask = '0;
    if (ret_valid && ret_rd_v) begin
      retire_mask = 32'd1 << ret_rd;
    end
  end

  assign busy_view     = busy_q & ~retire_mask;
  assign inflight_view = inflight_q - CNT_W'(ret_eff);
`else
  assign busy_view     = busy_q;
  assign inflight_view = inflight_q;
`endif

  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    if (dec_rs1_v && (dec_rs1 != 5'd0) && busy_view[dec_rs1]) begin
      raw = 1'b1;
    end
    if (dec_rs2_v && (dec_rs2 != 5'd0) && busy_view[dec_rs2]) begin
      raw = 1'b1;
    end
    if (dec_rd_v && (dec_rd != 5'd0) && busy_view[dec_rd]) begin
      waw = 1'b1;
    end
  end

  assign stall_raw = raw | waw;
  // Uses the registered state, so ls_done can never coincide with a new
  // load/store accept.
  assign stall_ls  = dec_ls && (ls_state_q != LS_IDLE);
  assign full      = (inflight_view == CNT_W'(MAX_INFLIGHT));

  // Deliberately independent of dec_valid so decode can look ahead.
  assign dec_ready = rst_n && (!iss_valid_q || iss_ready) &&
                     !stall_raw && !stall_ls && !full;

  assign accept    = dec_valid && dec_ready;
  assign iss_fire  = iss_valid_q && iss_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    iss_valid_d = iss_valid_q;
    if (accept) begin
      iss_valid_d = 1'b1;      // load, or drain-and-reload in one cycle
    end else if (iss_fire) begin
      iss_valid_d = 1'b0;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (ret_clr) begin
      busy_d[ret_rd] = 1'b0;
    end
    // Applied after the clear so a same-register set/clear leaves the bit set.
    if (accept && dec_rd_v && (dec_rd != 5'd0)) begin
      busy_d[dec_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, ret_eff})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    ls_state_d = ls_state_q;
    case (ls_state_q)
      LS_IDLE: begin
        if (accept && dec_ls) begin
          ls_state_d = LS_QUEUED;
        end
      end
      LS_QUEUED: begin
        // ls_done here belongs to nothing we issued and is ignored.
        if (iss_fire && iss_ls_q) begin
          ls_state_d = LS_WAIT;
        end
      end
      LS_WAIT: begin
        if (ls_done) begin
          ls_state_d = LS_IDLE;
        end
      end
      default: begin
        ls_state_d = LS_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_state_q <= LS_IDLE;
    end else begin
      ls_state_q <= ls_state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      busy_q      <= '0;
      inflight_q  <= '0;
    end else begin
      iss_valid_q <= iss_valid_d;
      busy_q      <= busy_d;
      inflight_q  <= inflight_d;
    end
  end

  // The issue payload only loads on accept, which also keeps it stable while
  // execute back-pressures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_op_q    <= '0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_rd_q    <= '0;
      iss_rd_v_q  <= 1'b0;
      iss_imm_v_q <= 1'b0;
      iss_ls_q    <= 1'b0;
      iss_imm_q   <= '0;
    end else if (accept) begin
      iss_op_q    <= dec_op;
      iss_rs1_q   <= dec_rs1;
      iss_rs2_q   <= dec_rs2;
      iss_rd_q    <= dec_rd;
      iss_rd_v_q  <= dec_rd_v;
      iss_imm_v_q <= dec_imm_v;
      iss_ls_q    <= dec_ls;
      iss_imm_q   <= dec_imm;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign iss_valid = iss_valid_q;
  assign iss_op    = iss_op_q;
  assign iss_rs1   = iss_rs1_q;
  assign iss_rs2   = iss_rs2_q;
  assign iss_rd    = iss_rd_q;
  assign iss_rd_v  = iss_rd_v_q;
  assign iss_imm_v = iss_imm_v_q;
  assign iss_ls    = iss_ls_q;
  assign iss_imm   = iss_imm_q;
  assign busy_map  = busy_q;
  assign inflight  = inflight_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed bench for issue_scoreboard. Stimulus drives inputs 1 ns after the
// rising edge and checks status at the falling edge. Every instruction the
// bench expects to be accepted is queued; a monitor pops and compares the
// issue payload whenever an execute handshake is about to happen.
// -----------------------------------------------------------------------------
module tb_issue_scoreboard;

  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 3;

`ifdef WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             dec_valid, dec_ready;
  logic [5:0]       dec_op;
  logic             dec_rs1_v, dec_rs2_v, dec_rd_v, dec_imm_v;
  logic [4:0]       dec_rs1, dec_rs2, dec_rd;
  logic [31:0]      dec_imm;
  logic             dec_ls;
  logic             iss_valid, iss_ready;
  logic [5:0]       iss_op;
  logic [4:0]       iss_rs1, iss_rs2, iss_rd;
  logic             iss_rd_v, iss_imm_v, iss_ls;
  logic [31:0]      iss_imm;
  logic             ret_valid, ret_rd_v;
  logic [4:0]       ret_rd;
  logic             ls_done;
  logic [31:0]      busy_map;
  logic [CNT_W-1:0] inflight;
  logic             stall_raw, stall_ls;

  always #5 clk = ~clk;

  issue_scoreboard #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_op(dec_op),
    .dec_rs1_v(dec_rs1_v), .dec_rs2_v(dec_rs2_v), .dec_rd_v(dec_rd_v),
    .dec_imm_v(dec_imm_v), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_imm(dec_imm), .dec_ls(dec_ls),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_rd_v(iss_rd_v), .iss_imm_v(iss_imm_v), .iss_ls(iss_ls),
    .iss_imm(iss_imm),
    .ret_valid(ret_valid), .ret_rd_v(ret_rd_v), .ret_rd(ret_rd),
    .ls_done(ls_done),
    .busy_map(busy_map), .inflight(inflight),
    .stall_raw(stall_raw), .stall_ls(stall_ls)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic        rs1_v;
    logic [4:0]  rs1;
    logic        rs2_v;
    logic [4:0]  rs2;
    logic        rd_v;
    logic [4:0]  rd;
    logic        imm_v;
    logic [31:0] imm;
    logic        ls;
  } ins_t;

  ins_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic [5:0] op, input logic rs1_v, input logic [4:0] rs1,
                              input logic rs2_v, input logic [4:0] rs2,
                              input logic rd_v, input logic [4:0] rd,
                              input logic imm_v, input logic [31:0] imm, input logic ls);
    ins_t i;
    i.op = op; i.rs1_v = rs1_v; i.rs1 = rs1; i.rs2_v = rs2_v; i.rs2 = rs2;
    i.rd_v = rd_v; i.rd = rd; i.imm_v = imm_v; i.imm = imm; i.ls = ls;
    return i;
  endfunction

  function automatic logic [63:0] payload(input ins_t i);
    return {8'd0, i.op, i.rs1, i.rs2, i.rd, i.rd_v, i.imm_v, i.ls, i.imm};
  endfunction

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (rst_n && iss_valid && iss_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_unexpected: got op=0x%0h rd=%0d, expected no instruction", iss_op, iss_rd);
      end else begin
        check("issue_payload",
              {8'd0, iss_op, iss_rs1, iss_rs2, iss_rd, iss_rd_v, iss_imm_v, iss_ls, iss_imm},
              payload(exp_q.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input ins_t i, input logic v);
    dec_valid = v;      dec_op  = i.op;
    dec_rs1_v = i.rs1_v; dec_rs1 = i.rs1;
    dec_rs2_v = i.rs2_v; dec_rs2 = i.rs2;
    dec_rd_v  = i.rd_v;  dec_rd  = i.rd;
    dec_imm_v = i.imm_v; dec_imm = i.imm;
    dec_ls    = i.ls;
  endtask

  // Present an instruction the bench expects to be accepted this cycle.
  task automatic issue(input ins_t i);
    present(i, 1'b1);
    exp_q.push_back(i);
  endtask

  task automatic retire(input logic v, input logic rd_v, input logic [4:0] rd);
    ret_valid = v; ret_rd_v = rd_v; ret_rd = rd;
  endtask

  function automatic ins_t addi(input logic [4:0] rd, input logic [31:0] imm);
    return mk(6'h13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, rd, 1'b1, imm, 1'b0);
  endfunction

  initial begin
    ins_t nop_i, add4, lw_i, sw_i, a_i, b_i, c_i;

    rst_n = 1'b0; iss_ready = 1'b0; ls_done = 1'b0;
    present(mk(6'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0), 1'b0);
    retire(1'b0, 1'b0, 5'd0);
    nop_i = mk(6'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 1'b0);

    // Reset state
    @(negedge clk);
    check("rst_dec_ready", dec_ready, 0);
    check("rst_iss_valid", iss_valid, 0);
    check("rst_busy", busy_map, 0);
    check("rst_inflight", inflight, 0);
    cyc(); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", dec_ready, 1);

    // Back-to-back independent ADDI
    iss_ready = 1'b1;
    cyc(); issue(addi(5'd1, 32'd5));  @(negedge clk); check("b2b_ready1", dec_ready, 1);
    cyc(); issue(addi(5'd2, 32'd7));  @(negedge clk); check("b2b_ready2", dec_ready, 1);
    cyc(); present(nop_i, 1'b0);      @(negedge clk);
    check("b2b_busy", busy_map, 32'h6);
    check("b2b_inflight", inflight, 2);
    cyc(); retire(1'b1, 1'b1, 5'd1);
    cyc(); retire(1'b1, 1'b1, 5'd2);  @(negedge clk);
    check("ret1_busy", busy_map, 32'h4);
    check("ret1_inflight", inflight, 1);
    cyc(); retire(1'b0, 1'b0, 5'd0);  @(negedge clk);
    check("ret2_busy", busy_map, 0);
    check("ret2_inflight", inflight, 0);
    // Spurious retire at zero must not underflow
    cyc(); retire(1'b1, 1'b0, 5'd0);
    cyc(); retire(1'b0, 1'b0, 5'd0);  @(negedge clk);
    check("underflow_inflight", inflight, 0);

    // RAW stall on x3, then WAW on x4
    add4 = mk(6'h33, 1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0, 32'd0, 1'b0);
    cyc(); issue(addi(5'd3, 32'd9));  @(negedge clk); check("raw_prod_ready", dec_ready, 1);
    cyc(); present(add4, 1'b1);       @(negedge clk);
    check("raw_stall1", stall_raw, 1);
    check("raw_ready1", dec_ready, 0);
    cyc();                            @(negedge clk);
    check("raw_stall2", stall_raw, 1);
    check("raw_ready2", dec_ready, 0);
    cyc(); present(add4, 1'b0); retire(1'b1, 1'b1, 5'd3); @(negedge clk);
    check("raw_ret_stall", stall_raw, !BYP);
    check("raw_ret_ready", dec_ready, BYP);
    cyc(); retire(1'b0, 1'b0, 5'd0); issue(add4); @(negedge clk);
    check("raw_after_stall", stall_raw, 0);
    check("raw_after_ready", dec_ready, 1);
    cyc(); present(addi(5'd4, 32'd1), 1'b0); @(negedge clk);
    check("waw_stall", stall_raw, 1);
    check("waw_busy", busy_map, 32'h10);
    cyc(); retire(1'b1, 1'b1, 5'd4);
    cyc(); retire(1'b0, 1'b0, 5'd0);  @(negedge clk);
    check("raw_end_busy", busy_map, 0);
    check("raw_end_inflight", inflight, 0);
    check("waw_cleared", stall_raw, 0);

    // In-flight limit
    for (int r = 5; r <= 8; r++) begin
      cyc(); issue(addi(5'(r), 32'(r))); @(negedge clk);
      check("lim_ready", dec_ready, 1);
    end
    cyc(); present(addi(5'd9, 32'd9), 1'b1); @(negedge clk);
    check("lim_full_inflight", inflight, 4);
    check("lim_full_ready", dec_ready, 0);
    check("lim_full_noraw", stall_raw, 0);
    cyc(); present(addi(5'd9, 32'd9), 1'b0); retire(1'b1, 1'b1, 5'd5); @(negedge clk);
    check("lim_ret_ready", dec_ready, BYP);
    cyc(); retire(1'b0, 1'b0, 5'd0); issue(addi(5'd9, 32'd9)); @(negedge clk);
    check("lim_after_inflight", inflight, 3);
    check("lim_after_ready", dec_ready, 1);
    cyc(); present(nop_i, 1'b0); retire(1'b1, 1'b1, 5'd6); @(negedge clk);
    check("lim_refill_inflight", inflight, 4);
    cyc(); retire(1'b1, 1'b1, 5'd7);
    cyc(); retire(1'b1, 1'b1, 5'd8);
    cyc(); retire(1'b1, 1'b1, 5'd9);
    cyc(); retire(1'b0, 1'b0, 5'd0); @(negedge clk);
    check("lim_end_inflight", inflight, 0);
    check("lim_end_busy", busy_map, 0);

    // Load/store serialization
    lw_i = mk(6'h03, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 1'b1, 32'd8, 1'b1);
    sw_i = mk(6'h23, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 32'd12, 1'b1);
    iss_ready = 1'b0;
    cyc(); issue(lw_i);               @(negedge clk); check("ls_first_ready", dec_ready, 1);
    cyc(); present(sw_i, 1'b1); ls_done = 1'b1; @(negedge clk);
    check("ls_queued_stall", stall_ls, 1);
    check("ls_queued_ready", dec_ready, 0);
    cyc(); ls_done = 1'b0;            @(negedge clk);
    check("ls_done_ignored", stall_ls, 1);
    cyc(); iss_ready = 1'b1;          @(negedge clk);
    check("ls_issue_stall", stall_ls, 1);
    check("ls_issue_ready", dec_ready, 0);
    cyc(); ls_done = 1'b1;            @(negedge clk);
    check("ls_wait_stall", stall_ls, 1);
    cyc(); ls_done = 1'b0; issue(sw_i); @(negedge clk);
    check("ls_free_stall", stall_ls, 0);
    check("ls_free_ready", dec_ready, 1);
    cyc(); present(sw_i, 1'b0);
    cyc(); ls_done = 1'b1;            @(negedge clk);
    check("ls_second_wait", stall_ls, 1);
    cyc(); ls_done = 1'b0; retire(1'b1, 1'b1, 5'd10); @(negedge clk);
    check("ls_second_free", stall_ls, 0);
    cyc(); retire(1'b1, 1'b0, 5'd0);
    cyc(); retire(1'b0, 1'b0, 5'd0);  @(negedge clk);
    check("ls_end_inflight", inflight, 0);
    check("ls_end_busy", busy_map, 0);

    // Execute backpressure with drain-and-reload
    a_i = mk(6'h13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1, 32'h1234, 1'b0);
    b_i = mk(6'h03, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b1, 32'h10, 1'b1);
    iss_ready = 1'b0;
    cyc(); issue(a_i);                @(negedge clk); check("bp_first_ready", dec_ready, 1);
    for (int k = 0; k < 3; k++) begin
      cyc(); present(b_i, 1'b1);      @(negedge clk);
      check("bp_ready", dec_ready, 0);
      check("bp_iss_valid", iss_valid, 1);
      check("bp_iss_hold", {iss_op, iss_rd, iss_imm}, {6'h13, 5'd1, 32'h1234});
    end
    cyc(); iss_ready = 1'b1; issue(b_i); @(negedge clk);
    check("bp_reload_ready", dec_ready, 1);
    cyc(); present(nop_i, 1'b0);      @(negedge clk);
    check("bp_reload_valid", iss_valid, 1);
    check("bp_busy", busy_map, 32'h6);
    check("bp_inflight", inflight, 2);

    // Reset mid-operation: busy=0x6, LS_WAIT, one instruction held in issue
    c_i = mk(6'h33, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h55, 1'b0);
    cyc(); iss_ready = 1'b0; issue(c_i); @(negedge clk);
    check("pre_rst_ready", dec_ready, 1);
    cyc(); present(sw_i, 1'b0);       @(negedge clk);
    check("pre_rst_stall_ls", stall_ls, 1);
    check("pre_rst_iss_valid", iss_valid, 1);
    check("pre_rst_inflight", inflight, 3);
    check("pre_rst_busy", busy_map, 32'h6);
    cyc(); rst_n = 1'b0; #1;
    exp_q.delete();
    check("mid_rst_busy", busy_map, 0);
    check("mid_rst_inflight", inflight, 0);
    check("mid_rst_iss_valid", iss_valid, 0);
    check("mid_rst_iss_op", iss_op, 0);
    check("mid_rst_ready", dec_ready, 0);
    check("mid_rst_stall_ls", stall_ls, 0);
    @(negedge clk);
    check("mid_rst_ready_hold", dec_ready, 0);
    cyc(); rst_n = 1'b1; present(addi(5'd4, 32'd3), 1'b0); @(negedge clk);
    check("rel_rst_ready", dec_ready, 1);
    cyc(); iss_ready = 1'b1; issue(addi(5'd4, 32'd3)); @(negedge clk);
    check("rel_accept_ready", dec_ready, 1);
    cyc(); present(nop_i, 1'b0);      @(negedge clk);
    cyc();                            @(negedge clk);
    check("rel_inflight", inflight, 1);
    check("rel_busy", busy_map, 32'h10);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
